// File: rtl/bus_slave_port.sv
// bus_slave_port: slave-side endpoint of the serial system bus.
// Deserializes address, burst length and write data from the granted master.
// Performs word accesses on a local single-port memory and serializes read
// data back to the master.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   master_valid/master_ready master handshake (valid rx bit / accepts tx bit)
//   rx_address/rx_burst_num   serial address / burst length, LSB first
//   rx_data                   serial write data, LSB first
//   write_en/read_en          request, sampled in IDLE only
//   tx_data/slave_valid       serial read data and its valid flag
//   slave_ready               slave samples master bits this cycle
//   mem_*                     local memory port; mem_rdata valid one cycle after mem_re
module bus_slave_port #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  master_valid,
  input  logic                  master_ready,
  input  logic                  rx_address,
  input  logic                  rx_burst_num,
  input  logic                  rx_data,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic                  tx_data,
  output logic                  slave_valid,
  output logic                  slave_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CntMax = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    StIdle, StAddr, StWdata, StMemWr, StRdReq, StRdWait, StRdata
  } state_e;

  state_e                 state_q, state_d;
  logic                   op_rd_q, op_rd_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;   // burst value, then beats remaining
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   mem_we_q, mem_we_d;
  logic                   mem_re_q, mem_re_d;
  logic                   slave_valid_q, slave_valid_d;

  always_comb begin
    state_d       = state_q;
    op_rd_d       = op_rd_q;
    addr_d        = addr_q;
    burst_d       = burst_q;
    wdata_d       = wdata_q;
    tx_sr_d       = tx_sr_q;
    cnt_d         = cnt_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    slave_valid_d = slave_valid_q;

    unique case (state_q)
      StIdle: begin
        if (master_valid && (write_en ^ read_en)) begin
          op_rd_d = read_en;
          addr_d  = {rx_address, addr_q[ADDR_WIDTH-1:1]};
          burst_d = {rx_burst_num, burst_q[BURST_WIDTH-1:1]};
          cnt_d   = CntW'(1);
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (master_valid) begin
          addr_d = {rx_address, addr_q[ADDR_WIDTH-1:1]};
          // Burst bits ride alongside address bits 0..BURST_WIDTH-1 only
          if (cnt_q < CntW'(BURST_WIDTH)) begin
            burst_d = {rx_burst_num, burst_q[BURST_WIDTH-1:1]};
          end
          if (cnt_q == CntW'(ADDR_WIDTH - 1)) begin
            cnt_d = '0;
            if (op_rd_q) begin
              state_d  = StRdReq;
              mem_re_d = 1'b1;
            end else begin
              state_d = StWdata;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWdata: begin
        if (master_valid) begin
          wdata_d = {rx_data, wdata_q[DATA_WIDTH-1:1]};
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            cnt_d    = '0;
            state_d  = StMemWr;
            mem_we_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StMemWr: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (burst_q != '0) begin
          burst_d = burst_q - BURST_WIDTH'(1);
          state_d = StWdata;
        end else begin
          state_d = StIdle;
        end
      end
      StRdReq: begin
        state_d = StRdWait;
      end
      StRdWait: begin
        tx_sr_d       = mem_rdata;
        slave_valid_d = 1'b1;
        state_d       = StRdata;
      end
      StRdata: begin
        if (master_ready) begin
          // Zero-fill so tx_data returns to 0 once the word is drained
          tx_sr_d = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            cnt_d         = '0;
            slave_valid_d = 1'b0;
            addr_d        = addr_q + ADDR_WIDTH'(1);
            if (burst_q != '0) begin
              burst_d  = burst_q - BURST_WIDTH'(1);
              state_d  = StRdReq;
              mem_re_d = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      op_rd_q       <= 1'b0;
      addr_q        <= '0;
      burst_q       <= '0;
      wdata_q       <= '0;
      tx_sr_q       <= '0;
      cnt_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      slave_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_rd_q       <= op_rd_d;
      addr_q        <= addr_d;
      burst_q       <= burst_d;
      wdata_q       <= wdata_d;
      tx_sr_q       <= tx_sr_d;
      cnt_q         <= cnt_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      slave_valid_q <= slave_valid_d;
    end
  end

  assign slave_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata);
  assign slave_valid = slave_valid_q;
  assign tx_data     = tx_sr_q[0];
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed testbench for bus_slave_port (ADDR_WIDTH=12, DATA_WIDTH=8, BURST_WIDTH=4).
module tb_bus_slave_port;

  logic        clk;
  logic        rst;
  logic        master_valid, master_ready;
  logic        rx_address, rx_burst_num, rx_data;
  logic        write_en, read_en;
  logic        tx_data, slave_valid, slave_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int lo_cnt = 0;
  int saved_we, saved_lo;

  logic [7:0] mem [4096];

  bus_slave_port #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (8),
    .BURST_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .master_valid(master_valid),
    .master_ready(master_ready),
    .rx_address  (rx_address),
    .rx_burst_num(rx_burst_num),
    .rx_data     (rx_data),
    .write_en    (write_en),
    .read_en     (read_en),
    .tx_data     (tx_data),
    .slave_valid (slave_valid),
    .slave_ready (slave_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local memory model with preloaded read patterns
  always @(posedge clk) begin
    if (!rst) begin
      mem[12'hFFF] <= 8'h81;
      mem[12'h000] <= 8'h7E;
      mem[12'h123] <= 8'hB6;
      mem_rdata    <= 8'h00;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (!slave_ready) lo_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then advance to the next mid-cycle point
  task automatic drive(input logic mv, input logic ra, input logic rb, input logic rd,
                       input logic we, input logic re);
    master_valid = mv;
    rx_address   = ra;
    rx_burst_num = rb;
    rx_data      = rd;
    write_en     = we;
    read_en      = re;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic rd, input logic [11:0] a, input logic [3:0] b,
                          input int stall_at);
    logic [11:0] bb;
    bb = {8'h00, b};
    for (int i = 0; i < 12; i++) begin
      if (i == stall_at && i > 0) begin
        repeat (2) drive(1'b0, ~a[i], 1'b1, 1'b1, 1'b0, 1'b0);
      end
      drive(1'b1, a[i], bb[i], 1'b0, (i == 0) && !rd, (i == 0) && rd);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input int beats, input logic [31:0] data,
                          input int stall_a, input int stall_d);
    logic [11:0] ea;
    send_hdr(1'b0, a, 4'(beats - 1), stall_a);
    for (int k = 0; k < beats; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (k == 0 && i == stall_d) begin
          repeat (2) drive(1'b0, 1'b0, 1'b0, ~data[8*k+i], 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, data[8*k+i], 1'b0, 1'b0);
      end
      ea = a + 12'(k);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_addr", 32'(mem_addr), 32'(ea));
      check("wr_mem_wdata", 32'(mem_wdata), 32'(data[8*k+:8]));
      check("wr_slave_ready_low", 32'(slave_ready), 32'd0);
      // Master keeps toggling rx_data here; the slave must ignore it
      drive(1'b1, 1'b0, 1'b0, ~data[8*k], 1'b0, 1'b0);
      check("wr_we_one_cycle", 32'(mem_we), 32'd0);
      check("wr_ready_back", 32'(slave_ready), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_read(input logic [11:0] a, input int beats, input logic [31:0] exp_data,
                         input int stall_a, input int stall_bit);
    logic [11:0] ea;
    send_hdr(1'b1, a, 4'(beats - 1), stall_a);
    master_valid = 1'b0;
    read_en      = 1'b0;
    for (int k = 0; k < beats; k++) begin
      ea = a + 12'(k);
      check("rd_mem_re", 32'(mem_re), 32'd1);
      check("rd_mem_addr", 32'(mem_addr), 32'(ea));
      check("rd_ready_low", 32'(slave_ready), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rd_re_one_cycle", 32'(mem_re), 32'd0);
      check("rd_wait_not_valid", 32'(slave_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        if (k == 0 && i == stall_bit) begin
          master_ready = 1'b0;
          repeat (3) begin
            check("rd_hold_valid", 32'(slave_valid), 32'd1);
            check("rd_hold_bit", 32'(tx_data), 32'(exp_data[8*k+i]));
            @(negedge clk);
          end
          master_ready = 1'b1;
        end
        check("rd_valid", 32'(slave_valid), 32'd1);
        check("rd_bit", 32'(tx_data), 32'(exp_data[8*k+i]));
        @(negedge clk);
      end
      check("rd_word_end_valid", 32'(slave_valid), 32'd0);
    end
  endtask

  initial begin
    rst          = 1'b0;
    master_ready = 1'b1;
    master_valid = 1'b0;
    rx_address   = 1'b0;
    rx_burst_num = 1'b0;
    rx_data      = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_slave_ready", 32'(slave_ready), 32'd1);
    check("rst_slave_valid", 32'(slave_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(slave_ready), 32'd1);

    // Both enables, or no master_valid: no request accepted, no shifting
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("both_en_no_we", 32'(mem_we), 32'd0);
    check("both_en_no_re", 32'(mem_re), 32'd0);
    check("both_en_addr", 32'(mem_addr), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("no_valid_addr", 32'(mem_addr), 32'd0);
    check("no_valid_ready", 32'(slave_ready), 32'd1);

    do_write(12'h0A5, 1, 32'h0000_003C, -1, -1);
    // Stalls during ADDR and WDATA
    do_write(12'h5A3, 1, 32'h0000_0096, 5, 3);

    // Burst read wrapping 0xFFF -> 0x000
    do_read(12'hFFF, 2, 32'h0000_7E81, -1, -1);
    // Backpressure mid-read
    do_read(12'h123, 1, 32'h0000_00B6, -1, 4);

    // Reset in the middle of a write after data bit 4
    saved_we = we_cnt;
    send_hdr(1'b0, 12'h200, 4'd0, -1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(slave_ready), 32'd1);
    check("midrst_valid", 32'(slave_valid), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wdata", 32'(mem_wdata), 32'd0);
    master_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_we_pulse", 32'(we_cnt - saved_we), 32'd0);
    do_write(12'h321, 1, 32'h0000_00A5, -1, -1);

    // Four-beat write burst
    saved_we = we_cnt;
    saved_lo = lo_cnt;
    do_write(12'h010, 4, 32'h4433_2211, -1, -1);
    check("burst_we_pulses", 32'(we_cnt - saved_we), 32'd4);
    check("burst_ready_low_cycles", 32'(lo_cnt - saved_lo), 32'd4);
    do_read(12'h012, 1, 32'h0000_0033, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
